// File: rtl/fifo_flag_ctrl.sv
// fifo_flag_ctrl: pointer, occupancy, status-flag and sticky-error control for a
// single-clock FIFO wrapped around an external dual-port RAM. Any depth >= 2 is
// supported; pointers wrap explicitly at FIFO_DEPTH-1 rather than by overflow.

`ifndef CFG_FIFO_DEPTH
`define CFG_FIFO_DEPTH 8
`endif

module fifo_flag_ctrl #(
  parameter int FIFO_DEPTH = `CFG_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_flush,
  input  logic                  i_valid_s,
  input  logic                  i_ready_m,
  input  logic [CNT_WIDTH-1:0]  i_almostfull_lvl,
  input  logic [CNT_WIDTH-1:0]  i_almostempty_lvl,
  input  logic                  i_err_clr,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_ready_s,
  output logic                  o_valid_m,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr, rd;

  // Accepted transfers; gated by reset_n so no RAM strobe escapes while in reset.
  always_comb begin
    wr = reset_n & i_valid_s & ~full_q & ~i_flush;
    rd = reset_n & i_ready_m & ~empty_q & ~i_flush;
  end

  // Next pointers and occupancy; flush returns everything to the reset point.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_WIDTH'(wr) - CNT_WIDTH'(rd);
    if (wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Flags are derived from next occupancy so they are registered but never stale;
  // thresholds are re-evaluated every cycle, transfer or not.
  always_comb begin
    full_d   = (count_d == DEPTH_CNT);
    empty_d  = (count_d == '0);
    afull_d  = (i_almostfull_lvl != '0) && (count_d >= i_almostfull_lvl);
    aempty_d = (count_d <= i_almostempty_lvl);
  end

  // Sticky errors: a new event in the clear cycle wins; flush cycles raise nothing
  // but leave pending errors alone.
  always_comb begin
    ovf_d = (ovf_q & ~i_err_clr) | (i_valid_s & full_q  & ~i_flush);
    udf_d = (udf_q & ~i_err_clr) | (i_ready_m & empty_q & ~i_flush);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Status flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Sticky error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Output mapping.
  always_comb begin
    o_wr_en       = wr;
    o_rd_en       = rd;
    o_wr_addr     = wr_ptr_q;
    o_rd_addr     = rd_ptr_q;
    o_ready_s     = ~full_q;
    o_valid_m     = ~empty_q;
    o_full        = full_q;
    o_empty       = empty_q;
    o_almostfull  = afull_q;
    o_almostempty = aempty_q;
    o_count       = count_q;
    o_overflow    = ovf_q;
    o_underflow   = udf_q;
  end

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Directed bench for fifo_flag_ctrl at depth 5 (non-power-of-two wrap).
module tb_fifo_flag_ctrl;

  localparam int DEPTH = 5;
  localparam int AW    = 3;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_flush = 1'b0, i_valid_s = 1'b0, i_ready_m = 1'b0, i_err_clr = 1'b0;
  logic [CW-1:0] i_almostfull_lvl = 3'd4, i_almostempty_lvl = 3'd1;
  logic          o_wr_en, o_rd_en, o_ready_s, o_valid_m, o_full, o_empty;
  logic          o_almostfull, o_almostempty, o_overflow, o_underflow;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  logic [CW-1:0] o_count;

  fifo_flag_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .i_flush(i_flush), .i_valid_s(i_valid_s),
    .i_ready_m(i_ready_m), .i_almostfull_lvl(i_almostfull_lvl),
    .i_almostempty_lvl(i_almostempty_lvl), .i_err_clr(i_err_clr),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_ready_s(o_ready_s), .o_valid_m(o_valid_m), .o_full(o_full), .o_empty(o_empty),
    .o_almostfull(o_almostfull), .o_almostempty(o_almostempty), .o_count(o_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  typedef struct {
    bit v, r, f, c;
    int afl, ael;
    bit wen, ren;
    int wa, ra;
    int cnt;
    bit full, emp, af, ae, ovf, udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, bit r, bit f, bit c, int afl, int ael,
                              bit wen, bit ren, int wa, int ra,
                              int cnt, bit full, bit emp, bit af, bit ae, bit ovf, bit udf);
    vec_t t;
    t.v = v; t.r = r; t.f = f; t.c = c; t.afl = afl; t.ael = ael;
    t.wen = wen; t.ren = ren; t.wa = wa; t.ra = ra;
    t.cnt = cnt; t.full = full; t.emp = emp; t.af = af; t.ae = ae; t.ovf = ovf; t.udf = udf;
    return t;
  endfunction

  task automatic chk_reset_vals(input int idx);
    chk("rst_count", idx, int'(o_count), 0);
    chk("rst_wr_addr", idx, int'(o_wr_addr), 0);
    chk("rst_rd_addr", idx, int'(o_rd_addr), 0);
    chk("rst_empty", idx, int'(o_empty), 1);
    chk("rst_almostempty", idx, int'(o_almostempty), 1);
    chk("rst_valid_m", idx, int'(o_valid_m), 0);
    chk("rst_full", idx, int'(o_full), 0);
    chk("rst_almostfull", idx, int'(o_almostfull), 0);
    chk("rst_ready_s", idx, int'(o_ready_s), 1);
    chk("rst_overflow", idx, int'(o_overflow), 0);
    chk("rst_underflow", idx, int'(o_underflow), 0);
    chk("rst_wr_en", idx, int'(o_wr_en), 0);
    chk("rst_rd_en", idx, int'(o_rd_en), 0);
  endtask

  initial begin
    //          v r f c afl ael | wen ren wa ra | cnt full emp af ae ovf udf
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 0,0, 1,0,0,0,1,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 1,0, 2,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 2,0, 3,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 3,0, 4,0,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 4,0, 5,1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 0,0, 0,0, 5,1,0,1,0,1,0)); // write while full
    vecs.push_back(mk(1,1,0,0, 4,1, 0,1, 0,0, 4,0,0,1,0,1,0)); // both at full
    vecs.push_back(mk(0,1,0,1, 4,1, 0,1, 0,1, 3,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0, 4,1, 0,1, 0,2, 2,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0, 4,1, 1,1, 0,3, 2,0,0,0,0,0,0)); // both at count 2
    vecs.push_back(mk(0,1,0,0, 4,1, 0,1, 1,4, 1,0,0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0, 4,1, 0,1, 1,0, 0,0,1,0,1,0,0)); // rd wraps
    vecs.push_back(mk(0,1,0,0, 4,1, 0,0, 1,1, 0,0,1,0,1,0,1)); // read while empty
    vecs.push_back(mk(0,1,0,1, 4,1, 0,0, 1,1, 0,0,1,0,1,0,1)); // set beats clear
    vecs.push_back(mk(1,1,0,0, 4,1, 1,0, 1,1, 1,0,0,0,1,0,1)); // both at empty
    vecs.push_back(mk(0,0,0,1, 4,1, 0,0, 2,1, 1,0,0,0,1,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 2,1, 2,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 3,1, 3,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 2,1, 0,0, 4,1, 3,0,0,1,0,0,0)); // lvl change, no transfer
    vecs.push_back(mk(0,0,0,0, 0,1, 0,0, 4,1, 3,0,0,0,0,0,0)); // lvl 0 disables
    vecs.push_back(mk(1,0,0,0, 0,1, 1,0, 4,1, 4,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,1, 1,0, 0,1, 5,1,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 0,0, 1,1, 5,1,0,1,0,1,0));
    vecs.push_back(mk(0,1,0,0, 4,1, 0,1, 1,1, 4,0,0,1,0,1,0));
    vecs.push_back(mk(0,1,0,0, 4,1, 0,1, 1,2, 3,0,0,0,0,1,0));
    vecs.push_back(mk(1,1,1,0, 4,1, 0,0, 1,3, 0,0,1,0,1,1,0)); // flush at count 3
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 0,0, 1,0,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,1, 4,1, 0,0, 1,0, 1,0,0,0,1,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 1,0, 2,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 4,1, 1,0, 2,0, 3,0,0,0,0,0,0));

    // Reset held: outputs at reset values even with requests asserted.
    i_valid_s = 1'b1; i_ready_m = 1'b1;
    #12;
    chk_reset_vals(-1);
    i_valid_s = 1'b0; i_ready_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      i_valid_s = vecs[k].v; i_ready_m = vecs[k].r;
      i_flush = vecs[k].f;   i_err_clr = vecs[k].c;
      i_almostfull_lvl = CW'(vecs[k].afl); i_almostempty_lvl = CW'(vecs[k].ael);
      #1;
      chk("wr_en", k, int'(o_wr_en), int'(vecs[k].wen));
      chk("rd_en", k, int'(o_rd_en), int'(vecs[k].ren));
      chk("wr_addr", k, int'(o_wr_addr), vecs[k].wa);
      chk("rd_addr", k, int'(o_rd_addr), vecs[k].ra);
      @(posedge clk);
      #1;
      chk("count", k, int'(o_count), vecs[k].cnt);
      chk("full", k, int'(o_full), int'(vecs[k].full));
      chk("empty", k, int'(o_empty), int'(vecs[k].emp));
      chk("ready_s", k, int'(o_ready_s), int'(!vecs[k].full));
      chk("valid_m", k, int'(o_valid_m), int'(!vecs[k].emp));
      chk("almostfull", k, int'(o_almostfull), int'(vecs[k].af));
      chk("almostempty", k, int'(o_almostempty), int'(vecs[k].ae));
      chk("overflow", k, int'(o_overflow), int'(vecs[k].ovf));
      chk("underflow", k, int'(o_underflow), int'(vecs[k].udf));
    end

    // Mid-burst async reset at count 3, asserted between clock edges.
    @(negedge clk);
    i_valid_s = 1'b1; i_ready_m = 1'b0; i_flush = 1'b0; i_err_clr = 1'b0;
    #2;
    chk("pre_rst_count", 100, int'(o_count), 3);
    reset_n = 1'b0;
    #1;
    chk_reset_vals(100);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_wr_en", 101, int'(o_wr_en), 1);
    chk("post_rst_wr_addr", 101, int'(o_wr_addr), 0);
    @(posedge clk);
    #1;
    chk("post_rst_count", 101, int'(o_count), 1);
    chk("post_rst_wr_addr_next", 101, int'(o_wr_addr), 1);
    i_valid_s = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
